// File: rtl/dma_pkg.sv
// Shared constants and types for the two-channel DMA controller.
//   ADDR_W     memory address and word-count width
//   DATA_W     memory word width
//   MEM_DEPTH  number of valid memory words; only the DMA_BOUNDS_CHECK_EN build uses it
//   state_t    sequencer states
//   desc_t     latched transfer descriptor {src, dst, len}
//   fits()     true when base+len stays inside the memory, computed one bit wider than ADDR_W
package dma_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 192;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] len;
    } desc_t;

    function automatic logic fits(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
        return ({1'b0, base} + {1'b0, len}) <= MEM_LIMIT;
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Two-way round-robin arbiter.
//   clk, reset  clock and synchronous active-high reset (pointer returns to channel 0)
//   req         per-channel request
//   accept      the requester took the offered grant this cycle
//   valid       at least one request is pending
//   gnt         index of the channel offered the grant
// The pointer channel wins when it requests; after every accepted grant the
// pointer moves to the channel that was not granted.
module dma_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       valid,
    output logic       gnt
);

    logic ptr_q;

    always_comb begin
        valid = |req;
        gnt   = req[ptr_q] ? ptr_q : ~ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (accept && valid) begin
            ptr_q <= ~gnt;
        end
    end

endmodule

// File: rtl/dma_channel_ctrl.sv
// Two-channel DMA controller copying word blocks inside the shared data memory.
//   clk, reset   clock and synchronous active-high reset
//   ch_req       per-channel level request
//   ch_src/dst   per-channel start addresses, channel n at [ADDR_W*n +: ADDR_W]
//   ch_len       per-channel word count, 0..255
//   ch_ack       1-cycle pulse when a descriptor is latched
//   ch_done      1-cycle pulse when a transfer finishes
//   ch_err       1-cycle pulse when a descriptor is rejected (bounds-check build only)
//   busy         high from the ack cycle through the done cycle
//   mem_wr       1 = write mem_wdata to mem_addr, 0 = read
//   mem_addr     memory address; arithmetic wraps modulo 2^ADDR_W
//   mem_wdata    write data
//   mem_rdata    read data, valid the cycle after a read address is presented
// Build option: define DMA_BOUNDS_CHECK_EN to reject descriptors that run past MEM_DEPTH.
// The memory's bidirectional data bus is formed outside this block from mem_wdata/mem_rdata/mem_wr.
//
// state | meaning
// IDLE  | wait for a request; grant, latch descriptor, pulse ack (or err)
// RD    | present src+idx as a read address
// CAP   | capture the returned word
// WR    | write the captured word to dst+idx, advance idx
// DONE  | pulse done for the granted channel
module dma_channel_ctrl
    import dma_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          ch_req,
    input  logic [2*ADDR_W-1:0] ch_src,
    input  logic [2*ADDR_W-1:0] ch_dst,
    input  logic [2*ADDR_W-1:0] ch_len,
    output logic [1:0]          ch_ack,
    output logic [1:0]          ch_done,
    output logic [1:0]          ch_err,
    output logic                busy,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t              state_q, state_d;
    desc_t               desc_q, desc_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   idx_inc;
    logic                chan_q, chan_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                arb_valid;
    logic                arb_gnt;
    logic                arb_accept;
    logic                reject;
    desc_t               req_desc;

    // Requests are masked while reset is high so no ack can escape in that cycle.
    dma_rr_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (ch_req & {2{~reset}}),
        .accept (arb_accept),
        .valid  (arb_valid),
        .gnt    (arb_gnt)
    );

    always_comb begin
        req_desc.src = arb_gnt ? ch_src[ADDR_W +: ADDR_W] : ch_src[0 +: ADDR_W];
        req_desc.dst = arb_gnt ? ch_dst[ADDR_W +: ADDR_W] : ch_dst[0 +: ADDR_W];
        req_desc.len = arb_gnt ? ch_len[ADDR_W +: ADDR_W] : ch_len[0 +: ADDR_W];
    end

`ifdef DMA_BOUNDS_CHECK_EN
    assign reject = !fits(req_desc.src, req_desc.len) || !fits(req_desc.dst, req_desc.len);
`else
    assign reject = 1'b0;
`endif

    assign idx_inc = idx_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        idx_d      = idx_q;
        chan_d     = chan_q;
        data_d     = data_q;
        arb_accept = 1'b0;
        ch_ack     = '0;
        ch_done    = '0;
        ch_err     = '0;
        busy       = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    // A rejected descriptor still consumes the turn so the other channel is not starved.
                    arb_accept = 1'b1;
                    if (reject) begin
                        ch_err[arb_gnt] = 1'b1;
                    end else begin
                        ch_ack[arb_gnt] = 1'b1;
                        busy            = 1'b1;
                        desc_d          = req_desc;
                        idx_d           = '0;
                        chan_d          = arb_gnt;
                        state_d         = (req_desc.len == '0) ? DONE : RD;
                    end
                end
            end
            RD: begin
                busy     = 1'b1;
                mem_addr = desc_q.src + idx_q;
                state_d  = CAP;
            end
            CAP: begin
                busy    = 1'b1;
                data_d  = mem_rdata;
                state_d = WR;
            end
            WR: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = desc_q.dst + idx_q;
                mem_wdata = data_q;
                idx_d     = idx_inc;
                state_d   = (idx_inc == desc_q.len) ? DONE : RD;
            end
            DONE: begin
                busy            = 1'b1;
                ch_done[chan_q] = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            desc_q  <= '0;
            idx_q   <= '0;
            chan_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            idx_q   <= idx_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_dma_channel_ctrl.sv
module tb_dma_channel_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ch_req = 2'b00;
    logic [15:0] ch_src = '0;
    logic [15:0] ch_dst = '0;
    logic [15:0] ch_len = '0;
    logic [1:0]  ch_ack;
    logic [1:0]  ch_done;
    logic [1:0]  ch_err;
    logic        busy;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [31:0] wmem [256];
    bit          written [256];

    dma_channel_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .ch_req    (ch_req),
        .ch_src    (ch_src),
        .ch_dst    (ch_dst),
        .ch_len    (ch_len),
        .ch_ack    (ch_ack),
        .ch_done   (ch_done),
        .ch_err    (ch_err),
        .busy      (busy),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        case (a)
            8'd1:    return 32'd8;
            8'd2:    return 32'd9;
            8'd3:    return 32'd12;
            8'd254:  return 32'h11;
            8'd255:  return 32'h22;
            8'd0:    return 32'h33;
            default: return 32'hA000_0000 | {24'd0, a};
        endcase
    endfunction

    function automatic logic [31:0] mem_at(input logic [7:0] a);
        return written[a] ? wmem[a] : init_val(a);
    endfunction

    // Synchronous-read memory model.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_rdata <= mem_at(mem_addr);
        if (mem_wr) begin
            wmem[mem_addr]    <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        wr_cnt   <= wr_cnt + (mem_wr ? 1 : 0);
        done_cnt <= done_cnt + int'(ch_done[0]) + int'(ch_done[1]);
        err_cnt  <= err_cnt + int'(ch_err[0]) + int'(ch_err[1]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic next_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_desc(input int ch, input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len);
        ch_src[ch*8 +: 8] = src;
        ch_dst[ch*8 +: 8] = dst;
        ch_len[ch*8 +: 8] = len;
    endtask

    task automatic wait_done(input int ch, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            next_sample();
            if (ch_done[ch]) begin
                at = cyc;
                break;
            end
        end
        check("done_seen", {31'd0, at >= 0}, 32'd1);
    endtask

    initial begin
        int a0, a1, d0, d1, base_wr, base_done;

        // Reset
        repeat (3) next_drive();
        reset = 1'b0;
        next_sample();
        check("rst_flags", {25'd0, ch_ack, ch_done, ch_err, busy}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);

        // 1: ch0 src=1 dst=20 len=3
        next_drive();
        set_desc(0, 8'd1, 8'd20, 8'd3);
        ch_req = 2'b01;
        a0 = cyc;
        next_sample();
        check("t1_ack", {30'd0, ch_ack}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        next_drive();
        ch_req = 2'b00;
        next_sample();
        check("t1_rd_addr", {24'd0, mem_addr}, 32'd1);
        check("t1_rd_wr", {31'd0, mem_wr}, 32'd0);
        wait_done(0, 40, d0);
        check("t1_latency", d0 - a0, 32'd10);
        check("t1_m20", mem_at(8'd20), 32'd8);
        check("t1_m21", mem_at(8'd21), 32'd9);
        check("t1_m22", mem_at(8'd22), 32'd12);
        next_sample();
        check("t1_busy_low", {31'd0, busy}, 32'd0);

        // 2: simultaneous requests after reset
        next_drive();
        reset = 1'b1;
        next_drive();
        reset = 1'b0;
        set_desc(0, 8'd30, 8'd40, 8'd2);
        set_desc(1, 8'd50, 8'd60, 8'd1);
        ch_req = 2'b11;
        a0 = cyc;
        next_sample();
        check("t2_ack_ch0", {30'd0, ch_ack}, 32'd1);
        next_drive();
        ch_req = 2'b10;
        wait_done(0, 40, d0);
        check("t2_lat0", d0 - a0, 32'd7);
        next_sample();
        a1 = cyc;
        check("t2_ack_ch1", {30'd0, ch_ack}, 32'd2);
        next_drive();
        ch_req = 2'b00;
        wait_done(1, 40, d1);
        check("t2_lat1", d1 - a1, 32'd4);
        next_drive();
        ch_req = 2'b11;
        next_sample();
        check("t2_ack_third", {30'd0, ch_ack}, 32'd1);
        next_drive();
        ch_req = 2'b00;
        wait_done(0, 40, d0);
        check("t2_m40", mem_at(8'd40), 32'hA000_001E);
        check("t2_m41", mem_at(8'd41), 32'hA000_001F);
        check("t2_m60", mem_at(8'd60), 32'hA000_0032);

        // 3: len=0 on ch1
        next_sample();
        base_wr = wr_cnt;
        next_drive();
        set_desc(1, 8'd5, 8'd6, 8'd0);
        ch_req = 2'b10;
        next_sample();
        check("t3_ack", {30'd0, ch_ack}, 32'd2);
        next_drive();
        ch_req = 2'b00;
        next_sample();
        check("t3_done", {30'd0, ch_done}, 32'd2);
        next_sample();
        check("t3_busy_low", {31'd0, busy}, 32'd0);
        check("t3_no_writes", wr_cnt - base_wr, 32'd0);
        check("t3_m6", mem_at(8'd6), 32'hA000_0006);

`ifdef DMA_BOUNDS_CHECK_EN
        // 4: out-of-range descriptor is rejected
        base_wr = wr_cnt;
        next_drive();
        set_desc(0, 8'd190, 8'd10, 8'd3);
        ch_req = 2'b01;
        next_sample();
        check("t4_err", {30'd0, ch_err}, 32'd1);
        check("t4_no_ack", {30'd0, ch_ack}, 32'd0);
        next_drive();
        ch_req = 2'b00;
        repeat (4) next_sample();
        check("t4_no_writes", wr_cnt - base_wr, 32'd0);
        check("t4_err_total", err_cnt, 32'd1);
`else
        // 4: address wrap 254,255,0
        next_drive();
        set_desc(0, 8'd254, 8'd10, 8'd3);
        ch_req = 2'b01;
        next_sample();
        check("t4_ack", {30'd0, ch_ack}, 32'd1);
        next_drive();
        ch_req = 2'b00;
        next_sample();
        check("t4_rd0", {24'd0, mem_addr}, 32'd254);
        next_sample();
        next_sample();
        check("t4_wr0_en", {31'd0, mem_wr}, 32'd1);
        check("t4_wr0_addr", {24'd0, mem_addr}, 32'd10);
        check("t4_wr0_data", mem_wdata, 32'h11);
        next_sample();
        check("t4_rd1", {24'd0, mem_addr}, 32'd255);
        next_sample();
        next_sample();
        next_sample();
        check("t4_rd2", {24'd0, mem_addr}, 32'd0);
        check("t4_rd2_wr", {31'd0, mem_wr}, 32'd0);
        wait_done(0, 40, d0);
        check("t4_m10", mem_at(8'd10), 32'h11);
        check("t4_m11", mem_at(8'd11), 32'h22);
        check("t4_m12", mem_at(8'd12), 32'h33);
`endif

        // 5: reset during WR of word 2 of 5
        next_sample();
        base_done = done_cnt;
        next_drive();
        set_desc(0, 8'd100, 8'd120, 8'd5);
        ch_req = 2'b01;
        next_sample();
        check("t5_ack", {30'd0, ch_ack}, 32'd1);
        next_drive();
        ch_req = 2'b00;
        repeat (5) next_drive();
        reset = 1'b1;
        next_sample();
        check("t5_in_wr", {31'd0, mem_wr}, 32'd1);
        check("t5_wr_addr", {24'd0, mem_addr}, 32'd121);
        next_drive();
        reset = 1'b0;
        next_sample();
        check("t5_flags", {25'd0, ch_ack, ch_done, ch_err, busy}, 32'd0);
        check("t5_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("t5_addr", {24'd0, mem_addr}, 32'd0);
        check("t5_wdata", mem_wdata, 32'd0);
        repeat (4) next_sample();
        check("t5_no_done", done_cnt - base_done, 32'd0);
        check("t5_m120", mem_at(8'd120), 32'hA000_0064);
        check("t5_m122", mem_at(8'd122), 32'hA000_007A);
        next_drive();
        set_desc(1, 8'd70, 8'd80, 8'd2);
        ch_req = 2'b10;
        a1 = cyc;
        next_sample();
        check("t5_new_ack", {30'd0, ch_ack}, 32'd2);
        next_drive();
        ch_req = 2'b00;
        wait_done(1, 40, d1);
        check("t5_new_lat", d1 - a1, 32'd7);
        check("t5_m80", mem_at(8'd80), 32'hA000_0046);
        check("t5_m81", mem_at(8'd81), 32'hA000_0047);

        // 6: ch_req dropped after ack, len=4
        next_sample();
        base_done = done_cnt;
        next_drive();
        set_desc(0, 8'd130, 8'd140, 8'd4);
        ch_req = 2'b01;
        a0 = cyc;
        next_sample();
        check("t6_ack", {30'd0, ch_ack}, 32'd1);
        next_drive();
        ch_req = 2'b00;
        wait_done(0, 60, d0);
        check("t6_lat", d0 - a0, 32'd13);
        repeat (4) next_sample();
        check("t6_done_once", done_cnt - base_done, 32'd1);
        check("t6_busy_low", {31'd0, busy}, 32'd0);
        check("t6_m140", mem_at(8'd140), 32'hA000_0082);
        check("t6_m141", mem_at(8'd141), 32'hA000_0083);
        check("t6_m142", mem_at(8'd142), 32'hA000_0084);
        check("t6_m143", mem_at(8'd143), 32'hA000_0085);

`ifndef DMA_BOUNDS_CHECK_EN
        check("no_err_pulses", err_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
